// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline register with DEPTH slots in series.
// Bubbles collapse toward the output; flush kills entries, stall_cnt saturates.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16,
    parameter int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [OCC_W-1:0]  occupancy
);

    logic [DEPTH-1:0]  valid;
    logic [DATA_W-1:0] data [DEPTH];
    logic [CTRL_W-1:0] ctrl [DEPTH];

    logic [DEPTH-1:0]  load_ok;
    logic [DEPTH-1:0]  src_valid;
    logic [DATA_W-1:0] src_data [DEPTH];
    logic [CTRL_W-1:0] src_ctrl [DEPTH];

    // A slot may load if any slot from it to the output is empty, or the
    // output drains; in_valid never feeds this path.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        load_ok  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            all_full   = all_full & valid[i];
            load_ok[i] = out_ready | !all_full;
        end
    end

    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        src_ctrl[0]  = in_ctrl;
        for (int i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid[i-1];
            src_data[i]  = data[i-1];
            src_ctrl[i]  = ctrl[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= '0;
                ctrl[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    valid[i] <= 1'b0;
                end else if (load_ok[i]) begin
                    valid[i] <= src_valid[i];
                    if (src_valid[i]) begin
                        data[i] <= src_data[i];
                        ctrl[i] <= src_ctrl[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (clr_cnt) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(valid[i]);
        end
    end

    assign in_ready  = load_ok[0];
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];
    assign out_ctrl  = ctrl[DEPTH-1] & {CTRL_W{valid[DEPTH-1]}};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (DEPTH 2, 3, 1)
// share one stimulus bus; each scenario checks the instance it targets.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ctrl;
    logic        out_ready;
    logic        flush;
    logic        clr_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // DEPTH=2, CTRL_W=3
    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [2:0]  a_out_ctrl;
    logic [15:0] a_stall_cnt;
    logic [1:0]  a_occ;

    // DEPTH=3, CTRL_W=4
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [3:0]  b_out_ctrl;
    logic [15:0] b_stall_cnt;
    logic [1:0]  b_occ;

    // DEPTH=1, CNT_W=4
    logic        c_in_ready, c_out_valid;
    logic [31:0] c_out_data;
    logic [3:0]  c_out_ctrl;
    logic [3:0]  c_stall_cnt;
    logic [0:0]  c_occ;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .DEPTH(2), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl[2:0]),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_ctrl(a_out_ctrl),
        .flush(flush), .clr_cnt(clr_cnt),
        .stall_cnt(a_stall_cnt), .occupancy(a_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .DEPTH(3), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .out_ctrl(b_out_ctrl),
        .flush(flush), .clr_cnt(clr_cnt),
        .stall_cnt(b_stall_cnt), .occupancy(b_occ)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(4), .DEPTH(1), .CNT_W(4)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(c_in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(c_out_valid), .out_ready(out_ready),
        .out_data(c_out_data), .out_ctrl(c_out_ctrl),
        .flush(flush), .clr_cnt(clr_cnt),
        .stall_cnt(c_stall_cnt), .occupancy(c_occ)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        total++;
        if ({a_out_valid, a_out_data, a_out_ctrl, a_occ, a_stall_cnt, a_in_ready}
            !== {1'b0, 32'h0, 3'h0, 2'd0, 16'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset_init: got v=%0b d=%0h c=%0h occ=%0d cnt=%0d rdy=%0b want 0/0/0/0/0/1",
                     a_out_valid, a_out_data, a_out_ctrl, a_occ, a_stall_cnt, a_in_ready);
        end
        rst = 1'b0;
        in_valid = 1'b1; in_data = 32'h55; in_ctrl = 4'h7; out_ready = 1'b0;
        repeat (3) tick();
        total++;
        if ({a_out_valid, a_in_ready, a_occ, a_stall_cnt} !== {1'b1, 1'b0, 2'd2, 16'd1}) begin
            bad++;
            $display("FAIL reset_prefill: got v=%0b rdy=%0b occ=%0d cnt=%0d want 1/0/2/1",
                     a_out_valid, a_in_ready, a_occ, a_stall_cnt);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if ({a_out_valid, a_out_data, a_out_ctrl, a_occ, a_stall_cnt, a_in_ready}
            !== {1'b0, 32'h0, 3'h0, 2'd0, 16'h0, 1'b1}) begin
            bad++;
            $display("FAIL reset_async: got v=%0b d=%0h c=%0h occ=%0d cnt=%0d rdy=%0b want 0/0/0/0/0/1",
                     a_out_valid, a_out_data, a_out_ctrl, a_occ, a_stall_cnt, a_in_ready);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        #1 rst = 1'b0;
        tick();
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_no_replay: got out_valid=%0b want 0", a_out_valid);
        end
        in_valid = 1'b1; in_data = 32'h0000_00AA; in_ctrl = 4'b0101;
        tick();
        in_valid = 1'b0;
        total++;
        if (a_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL latency_early: got out_valid=%0b want 0", a_out_valid);
        end
        tick();
        total++;
        if ({a_out_valid, a_out_data, a_out_ctrl} !== {1'b1, 32'hAA, 3'b101}) begin
            bad++;
            $display("FAIL latency_out: got v=%0b d=%0h c=%0b want v=1 d=aa c=101",
                     a_out_valid, a_out_data, a_out_ctrl);
        end
    endtask

    task automatic test_streaming();
        in_ctrl = 4'hF; out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1; in_data = 32'(k);
            tick();
            if (k >= 2) begin
                total++;
                if ({a_out_valid, a_out_data, a_out_ctrl} !== {1'b1, 32'(k - 1), 3'h7}) begin
                    bad++;
                    $display("FAIL stream_%0d: got v=%0b d=%0h c=%0h want v=1 d=%0h c=7",
                             k - 1, a_out_valid, a_out_data, a_out_ctrl, k - 1);
                end
            end
        end
        in_valid = 1'b0;
        tick();
        total++;
        if ({a_out_valid, a_out_data} !== {1'b1, 32'd8}) begin
            bad++;
            $display("FAIL stream_8: got v=%0b d=%0h want v=1 d=8", a_out_valid, a_out_data);
        end
        tick();
        total++;
        if (a_stall_cnt !== 16'd0) begin
            bad++;
            $display("FAIL stream_nostall: got stall_cnt=%0d want 0", a_stall_cnt);
        end
    endtask

    task automatic test_masking();
        total++;
        if ({a_out_valid, a_out_ctrl, a_out_data, a_occ} !== {1'b0, 3'h0, 32'd8, 2'd0}) begin
            bad++;
            $display("FAIL mask_empty: got v=%0b c=%0h d=%0h occ=%0d want v=0 c=0 d=8 occ=0",
                     a_out_valid, a_out_ctrl, a_out_data, a_occ);
        end
    endtask

    task automatic test_collapse();
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        out_ready = 1'b0; in_ctrl = 4'h1;
        in_valid = 1'b1; in_data = 32'hA;
        tick();
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 32'hB;
        tick();
        in_valid = 1'b0;
        total++;
        if ({b_occ, b_out_valid, b_out_data} !== {2'd2, 1'b1, 32'hA}) begin
            bad++;
            $display("FAIL collapse_gap: got occ=%0d v=%0b d=%0h want occ=2 v=1 d=a",
                     b_occ, b_out_valid, b_out_data);
        end
        tick();
        tick();
        total++;
        if ({b_occ, b_in_ready, b_out_data} !== {2'd2, 1'b1, 32'hA}) begin
            bad++;
            $display("FAIL collapse_compact: got occ=%0d rdy=%0b d=%0h want occ=2 rdy=1 d=a",
                     b_occ, b_in_ready, b_out_data);
        end
        in_valid = 1'b1; in_data = 32'hC;
        tick();
        in_valid = 1'b0;
        total++;
        if ({b_occ, b_in_ready} !== {2'd3, 1'b0}) begin
            bad++;
            $display("FAIL collapse_full: got occ=%0d rdy=%0b want occ=3 rdy=0", b_occ, b_in_ready);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if ({b_in_ready, b_out_data} !== {1'b1, 32'hA}) begin
            bad++;
            $display("FAIL ready_comb: got rdy=%0b d=%0h want rdy=1 d=a", b_in_ready, b_out_data);
        end
        tick();
        total++;
        if ({b_out_valid, b_out_data} !== {1'b1, 32'hB}) begin
            bad++;
            $display("FAIL drain_b: got v=%0b d=%0h want v=1 d=b", b_out_valid, b_out_data);
        end
        tick();
        total++;
        if ({b_out_valid, b_out_data} !== {1'b1, 32'hC}) begin
            bad++;
            $display("FAIL drain_c: got v=%0b d=%0h want v=1 d=c", b_out_valid, b_out_data);
        end
        tick();
        total++;
        if (b_out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drain_empty: got v=%0b want 0", b_out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_ctrl = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = 32'h100 + 32'(k);
            tick();
        end
        total++;
        if ({b_occ, b_out_ctrl, b_out_data} !== {2'd3, 4'hF, 32'h101}) begin
            bad++;
            $display("FAIL flush_fill: got occ=%0d c=%0h d=%0h want occ=3 c=f d=101",
                     b_occ, b_out_ctrl, b_out_data);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        total++;
        if ({b_out_valid, b_out_ctrl, b_occ, b_in_ready, b_out_data}
            !== {1'b0, 4'h0, 2'd0, 1'b1, 32'h101}) begin
            bad++;
            $display("FAIL flush_kill: got v=%0b c=%0h occ=%0d rdy=%0b d=%0h want 0/0/0/1/101",
                     b_out_valid, b_out_ctrl, b_occ, b_in_ready, b_out_data);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (b_out_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_discard_%0d: got v=%0b d=%0h want v=0", k, b_out_valid, b_out_data);
            end
        end
    endtask

    task automatic test_counter();
        clr_cnt = 1'b1; out_ready = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++;
        if (c_stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL cnt_clear0: got %0d want 0", c_stall_cnt);
        end
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total++;
        if ({c_out_valid, c_stall_cnt} !== {1'b1, 4'd0}) begin
            bad++;
            $display("FAIL cnt_load: got v=%0b cnt=%0d want v=1 cnt=0", c_out_valid, c_stall_cnt);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 5 || k == 14) begin
                total++;
                if (c_stall_cnt !== 4'(k)) begin
                    bad++;
                    $display("FAIL cnt_step_%0d: got %0d want %0d", k, c_stall_cnt, k);
                end
            end
        end
        total++;
        if (c_stall_cnt !== 4'd15) begin
            bad++;
            $display("FAIL cnt_saturate: got %0d want 15", c_stall_cnt);
        end
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++;
        if (c_stall_cnt !== 4'd0) begin
            bad++;
            $display("FAIL cnt_clr_stall: got %0d want 0", c_stall_cnt);
        end
        tick();
        total++;
        if (c_stall_cnt !== 4'd1) begin
            bad++;
            $display("FAIL cnt_after_clr1: got %0d want 1", c_stall_cnt);
        end
        tick();
        total++;
        if (c_stall_cnt !== 4'd2) begin
            bad++;
            $display("FAIL cnt_after_clr2: got %0d want 2", c_stall_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        out_ready = 1'b1; flush = 1'b0; clr_cnt = 1'b0;
        test_reset();
        test_streaming();
        test_masking();
        test_collapse();
        test_flush();
        test_counter();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the MIPS datapath. It replaces fixed, per-boundary latch pairs with one generic block of configurable payload width and depth. It uses a valid/ready handshake with bubble collapse, and supports synchronous flush and control-bit masking on invalid slots. A saturating stall counter is included for performance monitoring. It sits between any two pipeline stages (ID/EX, EX/MEM, MEM/WB); control fields such as regwrite/memtoreg/memwrite/jumplink go on the ctrl bus, while operands, aluout, writereg and pcplus4 go on the data bus.

## Interface
- DATA_W, 32: payload (data) width in bits.
- CTRL_W, 4: control-bit width; forced to zero at the output when the slot is invalid.
- DEPTH, 1: number of register slots in series, ≥1.
- CNT_W, 16: stall counter width.
- OCC_W, $clog2(DEPTH+1): occupancy output width.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents a valid entry.
- in_ready  out  1  slot 0 can load this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- out_valid  out  1  last slot holds a valid entry.
- out_ready  in  1  downstream accepts (low = stall).
- out_data  out  DATA_W  last-slot payload.
- out_ctrl  out  CTRL_W  last-slot ctrl ANDed with out_valid.
- flush  in  1  synchronous kill of all slots.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating stall-cycle count.
- occupancy  out  OCC_W  number of valid slots.

## Operation
- **Slots:** slots 0..DEPTH-1 each hold valid, data and ctrl. Slot 0 is the input side; slot DEPTH-1 drives the outputs.
- **Combinational load chain:**
  - load_ok[DEPTH-1] = !valid[DEPTH-1] | out_ready.
  - load_ok[i] = !valid[i] | load_ok[i+1].
  - in_ready = load_ok[0].
  - No combinational path exists from in_valid to in_ready.
- **Per rising edge, each slot i with load_ok[i]:**
  - valid[i] ← source valid, where the source is in_valid for i=0 and valid[i-1] otherwise.
  - data[i] and ctrl[i] load from the source only when the source is valid; otherwise they hold.
- **Holding:** slots without load_ok hold all state.
- **Bubble collapse:** a bubble (invalid slot) ahead of a stalled entry is filled, so entries compact toward the output while out_ready is low.
- **Flush:**
  - flush=1 clears every valid bit on the edge and overrides all loads.
  - Data and ctrl registers hold.
  - An input handshake in the flush cycle is discarded.
  - An output handshake in the flush cycle counts as delivered.
- **stall_cnt:**
  - Increments each cycle where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - clr_cnt takes priority over increment (the counter reads 0 after the edge).
- **Occupancy:** combinational popcount of the valid bits.

## Timing
- **Reset:** async rst clears all valid, data, ctrl and stall_cnt immediately. Resulting outputs:
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, stall_cnt=0.
  - in_ready=1.
- Reset asserted mid-operation drops all in-flight entries; nothing is output after deassert until new input arrives.
- **Latency:** an entry accepted at edge N appears on out_valid after edge N+DEPTH-1, i.e. DEPTH cycles through an empty pipe.
- **Throughput:** one entry per cycle when out_ready is held high.
- **Full/stall:**
  - All DEPTH slots valid with out_ready=0 gives in_ready=0.
  - in_ready rises in the same cycle out_ready rises (combinational), giving simultaneous accept and drain.
- **Empty pipe:** out_valid=0 and out_ctrl=0 regardless of stale ctrl contents; out_data holds its last value.
- **Flush with stall:** flush while full and stalled leaves occupancy=0 and in_ready=1 on the next cycle.
- **Counter wrap:** stall_cnt never wraps.

## Test plan
- **Reset values:** assert rst mid-stream with DEPTH=2 → outputs are 0 immediately and in_ready=1. After deassert, feed in_data=0x0000_00AA, ctrl=3'b101 → out_valid rises 2 cycles later with out_data=0xAA and out_ctrl=3'b101.
- **Streaming:** 8 back-to-back entries 1..8 with out_ready=1 and DEPTH=2 → outputs 1..8 on consecutive cycles with no gaps; stall_cnt stays 0.
- **Backpressure/collapse:** DEPTH=3 with a bubble between entries A and B, and out_ready=0 → B advances until occupancy=2 and slots are compacted, and in_ready=1 still. A third entry C fills the pipe → occupancy=3 and in_ready=0. out_ready=1 → A, B, C delivered on consecutive cycles.
- **Flush:** pipe full with ctrl=4'hF in every slot, pulse flush together with in_valid=1 → next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed-cycle input never appears.
- **Counter:** CNT_W=4, hold a valid entry stalled for 20 cycles → stall_cnt saturates at 15. clr_cnt=1 during the stall → reads 0, then counts 1, 2, ...
- **Masking:** after the output drains, out_ctrl=0 while out_data still shows the last payload.
